// File: rtl/rgb_color_pkg.sv
// Shared colour-select constants, default RGB332 codes and FSM
// state encoding for the RGB332 pattern generator.
package rgb_color_pkg;

    // Same encoding as the red/green classifier output.
    localparam logic [1:0] COLOR_NONE  = 2'b00;
    localparam logic [1:0] COLOR_RED   = 2'b01;
    localparam logic [1:0] COLOR_GREEN = 2'b10;

    // Default RGB332 codes {R[7:5],G[4:2],B[1:0]}.
    localparam logic [7:0] DEF_RED_CODE   = 8'hA0;
    localparam logic [7:0] DEF_GREEN_CODE = 8'h1C;
    localparam logic [7:0] DEF_BG_CODE    = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rgb332_color_pattern_gen_raster_counter.sv
// Raster x/y/frame counters with clear and advance enable.
// Ports: clk, rst, clr, adv in; last_x/last_y/last_frame, x_nxt/y_nxt out.
module raster_counter #(
    parameter int unsigned H_ACTIVE   = 64,
    parameter int unsigned V_ACTIVE   = 48,
    parameter int unsigned NUM_FRAMES = 1,
    localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
    localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic          last_x,
    output logic          last_y,
    output logic          last_frame,
    output logic [XW-1:0] x_nxt,
    output logic [YW-1:0] y_nxt
);

    localparam int unsigned FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [FW-1:0] F_LAST = FW'(NUM_FRAMES - 1);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [FW-1:0] frame;
    logic [FW-1:0] f_nxt;

    assign last_x     = (x == X_LAST);
    assign last_y     = (y == Y_LAST);
    assign last_frame = (frame == F_LAST);

    // Next-coordinate values are exported so the top can register
    // the pixel that will be presented after this edge.
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        f_nxt = frame;
        if (clr) begin
            x_nxt = '0;
            y_nxt = '0;
            f_nxt = '0;
        end else if (adv) begin
            if (last_x) begin
                x_nxt = '0;
                if (last_y) begin
                    y_nxt = '0;
                    f_nxt = last_frame ? '0 : frame + 1'b1;
                end else begin
                    y_nxt = y + 1'b1;
                end
            end else begin
                x_nxt = x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x     <= '0;
            y     <= '0;
            frame <= '0;
        end else begin
            x     <= x_nxt;
            y     <= y_nxt;
            frame <= f_nxt;
        end
    end

endmodule

// File: rtl/rgb332_color_pattern_gen.sv
// Synthetic RGB332 raster source: frames with a red/green patch on a background.
// Ports: clk, rst, start, color_sel, pix_ready in; pix_valid, RGB, sof, eol, eof, busy, done out.
module rgb332_color_pattern_gen
    import rgb_color_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 64,
    parameter int unsigned V_ACTIVE   = 48,
    parameter int unsigned PATCH_X0   = 16,
    parameter int unsigned PATCH_W    = 16,
    parameter int unsigned PATCH_Y0   = 16,
    parameter int unsigned PATCH_H    = 16,
    parameter int unsigned NUM_FRAMES = 1,
    parameter logic [7:0]  RED_CODE   = DEF_RED_CODE,
    parameter logic [7:0]  GREEN_CODE = DEF_GREEN_CODE,
    parameter logic [7:0]  BG_CODE    = DEF_BG_CODE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] color_sel,
    input  logic       pix_ready,
    output logic       pix_valid,
    output logic [7:0] RGB,
    output logic       sof,
    output logic       eol,
    output logic       eof,
    output logic       busy,
    output logic       done
);

    localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    state_t        state;
    logic [1:0]    color_q;
    logic          xfer;
    logic          clr;
    logic          adv;
    logic          last_x;
    logic          last_y;
    logic          last_frame;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;

    assign xfer = pix_valid & pix_ready;
    assign clr  = (state != ST_RUN);
    assign adv  = (state == ST_RUN) & xfer;

    raster_counter #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .NUM_FRAMES (NUM_FRAMES)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .adv        (adv),
        .last_x     (last_x),
        .last_y     (last_y),
        .last_frame (last_frame),
        .x_nxt      (x_nxt),
        .y_nxt      (y_nxt)
    );

    // 33-bit compare so PATCH_X0+PATCH_W cannot wrap.
    function automatic logic [7:0] pix_code(
        input logic [XW-1:0] px,
        input logic [YW-1:0] py,
        input logic [1:0]    sel
    );
        logic in_x;
        logic in_y;
        in_x = (33'(px) >= 33'(PATCH_X0)) &&
               (33'(px) <  33'(PATCH_X0) + 33'(PATCH_W));
        in_y = (33'(py) >= 33'(PATCH_Y0)) &&
               (33'(py) <  33'(PATCH_Y0) + 33'(PATCH_H));
        if (in_x && in_y && sel == COLOR_RED)
            return RED_CODE;
        else if (in_x && in_y && sel == COLOR_GREEN)
            return GREEN_CODE;
        else
            return BG_CODE;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            color_q   <= COLOR_NONE;
            pix_valid <= 1'b0;
            RGB       <= '0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Counters are held clear in IDLE, so x_nxt/y_nxt are 0.
                        state     <= ST_RUN;
                        color_q   <= color_sel;
                        pix_valid <= 1'b1;
                        busy      <= 1'b1;
                        RGB       <= pix_code(x_nxt, y_nxt, color_sel);
                        sof       <= 1'b1;
                        eol       <= (x_nxt == X_LAST);
                        eof       <= (x_nxt == X_LAST) && (y_nxt == Y_LAST);
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        if (last_x && last_y && last_frame) begin
                            state     <= ST_DONE;
                            pix_valid <= 1'b0;
                            busy      <= 1'b0;
                            RGB       <= '0;
                            sof       <= 1'b0;
                            eol       <= 1'b0;
                            eof       <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            RGB <= pix_code(x_nxt, y_nxt, color_q);
                            sof <= (x_nxt == '0) && (y_nxt == '0);
                            eol <= (x_nxt == X_LAST);
                            eof <= (x_nxt == X_LAST) && (y_nxt == Y_LAST);
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb332_color_pattern_gen.sv
// Randomized self-checking bench for rgb332_color_pattern_gen.
// Drives/samples 1ns after each rising edge; reference model from raster rules.
module tb_rgb332_color_pattern_gen;

    localparam int PIX = 64 * 48;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic [1:0] color_sel = 2'b00;
    logic       pix_ready = 1'b0;

    logic       v1, s1, l1, e1, b1, d1;
    logic [7:0] c1;
    logic       v2, s2, l2, e2, b2, d2;
    logic [7:0] c2;

    logic       pick2 = 1'b0;
    logic       ov, osof, oeol, oeof, ob, od;
    logic [7:0] orgb;
    logic [13:0] allout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rgb332_color_pattern_gen dut (
        .clk(clk), .rst(rst), .start(start1), .color_sel(color_sel),
        .pix_ready(pix_ready), .pix_valid(v1), .RGB(c1), .sof(s1),
        .eol(l1), .eof(e1), .busy(b1), .done(d1)
    );

    rgb332_color_pattern_gen #(.NUM_FRAMES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .color_sel(color_sel),
        .pix_ready(pix_ready), .pix_valid(v2), .RGB(c2), .sof(s2),
        .eol(l2), .eof(e2), .busy(b2), .done(d2)
    );

    always_comb begin
        ov   = pick2 ? v2 : v1;
        orgb = pick2 ? c2 : c1;
        osof = pick2 ? s2 : s1;
        oeol = pick2 ? l2 : l1;
        oeof = pick2 ? e2 : e1;
        ob   = pick2 ? b2 : b1;
        od   = pick2 ? d2 : d1;
        allout = {ov, ob, od, osof, oeol, oeof, orgb};
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected {RGB,sof,eol,eof} for the n-th transferred pixel of a run.
    function automatic logic [10:0] model(input int n, input logic [1:0] sel);
        int p, x, y;
        bit in_patch;
        logic [7:0] c;
        p = n % PIX;
        x = p % 64;
        y = p / 64;
        in_patch = (x >= 16) && (x < 32) && (y >= 16) && (y < 32);
        if (in_patch && sel == 2'b01)      c = 8'hA0;
        else if (in_patch && sel == 2'b10) c = 8'h1C;
        else                               c = 8'h00;
        return {c, p == 0, x == 63, p == PIX - 1};
    endfunction

    task automatic run(input bit use2, input logic [1:0] sel,
                       input int rdy_pct, input bit disturb,
                       input int abort_at);
        int nf, npix, cnt, cyc, patch, exp_patch;
        bit stalled;
        logic [10:0] prev;
        nf = use2 ? 2 : 1;
        npix = nf * PIX;
        pick2 = use2;
        @(posedge clk); #1;
        color_sel = sel;
        if (use2) start2 = 1'b1;
        else      start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
        check("first_pix", {29'd0, ov, ob, osof}, 32'h7);
        cnt = 0; cyc = 0; patch = 0; stalled = 0; prev = '0;
        while (cnt < npix && cyc < npix * 6 + 100) begin
            if (abort_at >= 0 && cnt == abort_at) begin
                rst = 1'b1;
                #1;
                check("rst_zero", {18'd0, allout}, 32'h0);
                @(posedge clk); #1;
                rst = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check("abort_idle", {18'd0, allout}, 32'h0);
                return;
            end
            check("run_state", {29'd0, ov, ob, od}, 32'h6);
            if (stalled)
                check("stall_hold", {21'd0, orgb, osof, oeol, oeof},
                      {21'd0, prev});
            pix_ready = ($urandom_range(99) < rdy_pct);
            if (disturb) begin
                color_sel = 2'($urandom);
                if (use2) start2 = 1'($urandom);
                else      start1 = 1'($urandom);
            end
            if (ov && pix_ready) begin
                check("pixel", {21'd0, orgb, osof, oeol, oeof},
                      {21'd0, model(cnt, sel)});
                if (orgb != 8'h00) patch++;
                cnt++;
                stalled = 0;
            end else begin
                stalled = 1;
                prev = {orgb, osof, oeol, oeof};
            end
            @(posedge clk); #1;
            cyc++;
        end
        start1 = 1'b0;
        start2 = 1'b0;
        exp_patch = (sel == 2'b01 || sel == 2'b10) ? 256 * nf : 0;
        check("xfer_count", cnt, npix);
        check("patch_count", patch, exp_patch);
        check("done_pulse", {29'd0, od, ov, ob}, 32'h4);
        @(posedge clk); #1;
        check("done_clear", {18'd0, allout}, 32'h0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 check("reset_zero", {18'd0, allout}, 32'h0);
        check("reset_zero2", {18'd0, v2, b2, d2, s2, l2, e2, c2}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("idle_zero", {18'd0, allout}, 32'h0);
        rst = 1'b1;
        #2 check("idle_rst", {18'd0, allout}, 32'h0);
        rst = 1'b0;

        run(1'b0, 2'b01, 100, 1'b0, -1);
        run(1'b0, 2'b01, 50,  1'b0, -1);
        run(1'b0, 2'b10, 60,  1'b0, -1);
        run(1'b0, 2'b11, 100, 1'b0, -1);
        run(1'b0, 2'b01, 70,  1'b1, -1);
        run(1'b0, 2'b10, 100, 1'b0, 1000);
        run(1'b0, 2'b10, 80,  1'b0, -1);
        run(1'b1, 2'b01, 75,  1'b0, -1);
        run(1'b1, 2'b10, 100, 1'b1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
